// File: rtl/encoder_16x4_seq_pkg.sv
// Shared types and constants for the 16-to-4 sequential encoder.
package enc_pkg;

  localparam int VEC_W = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic single_bit(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/encoder_16x4_seq_if.sv
// Request-in / index-out handshake bundle for encoder_16x4_seq.
interface encoder_16x4_seq_if;
  import enc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             zero_err;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_err
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_err
  );

endinterface

// File: rtl/encoder_16x4_seq_prio_enc16.sv
// Combinational 16-bit find-first-set: lowest set bit index plus any-bit flag.
module prio_enc16
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_16x4_seq.sv
// Sequential 16-to-4 encoder: latches a multi-hot vector and emits one
// index per handshake. Define ENC_ROUND_ROBIN_EN to select the first set
// bit at or above a persistent pointer instead of fixed lowest-first.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for a vector
//   BUSY  | emitting indices of pending, one per out handshake
module encoder_16x4_seq
  import enc_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  encoder_16x4_seq_if.slave bus
);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] pending, pending_nxt;
  logic [IDX_W-1:0] idx_hold;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             last;
  logic             hs;
  logic             zero_err_q;

  assign last = single_bit(pending);
  assign hs   = (state == BUSY) && bus.out_ready && sel_any;

`ifdef ENC_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;
  logic [VEC_W-1:0] masked;
  logic [IDX_W-1:0] idx_m, idx_u;
  logic             any_m, any_u;

  // Bits at or above the pointer get first pick; otherwise wrap to the lowest.
  assign masked = pending & ({VEC_W{1'b1}} << ptr);

  prio_enc16 u_masked (.vec(masked),  .idx(idx_m), .any(any_m));
  prio_enc16 u_full   (.vec(pending), .idx(idx_u), .any(any_u));

  assign sel_idx = any_m ? idx_m : idx_u;
  assign sel_any = any_m | any_u;

  // Pointer moves past each emitted index and survives across vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= '0;
    else if (hs) ptr <= sel_idx + IDX_W'(1);
  end
`else
  prio_enc16 u_prio (.vec(pending), .idx(sel_idx), .any(sel_any));
`endif

  // Next state and next pending vector.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (bus.in_valid && (bus.in_vec != '0)) begin
          pending_nxt = bus.in_vec;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
          pending_nxt = pending & ~(VEC_W'(1) << sel_idx);
          if (last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pending vector, last-emitted index and zero-vector flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      idx_hold   <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      zero_err_q <= (state == IDLE) && bus.in_valid && (bus.in_vec == '0);
      if (hs) idx_hold <= sel_idx;
    end
  end

  // All outputs come from registered state only; idx_hold keeps out_idx
  // steady once the vector has drained.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == BUSY);
  assign bus.out_idx   = (state == BUSY) ? sel_idx : idx_hold;
  assign bus.out_last  = (state == BUSY) && last;
  assign bus.zero_err  = zero_err_q;

endmodule

// File: doc/encoder_16x4_seq.md
ENCODER_16X4_SEQ -- requirements
Module: encoder_16x4_seq

Interface
REQ-001 Parameters: none; widths are fixed at 16-bit vector in, 4-bit index out.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_vec is valid this cycle.
REQ-005 in_ready  output  1  block can accept a new vector.
REQ-006 in_vec  input  16  one-hot or multi-hot request vector.
REQ-007 out_valid  output  1  out_idx holds a valid encoded index.
REQ-008 out_ready  input  1  consumer accepts out_idx this cycle.
REQ-009 out_idx  output  4  binary index of the selected set bit.
REQ-010 out_last  output  1  out_idx is the final index of the current vector.
REQ-011 zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

Function
REQ-012 Two-state FSM, IDLE and BUSY; in_ready SHALL be 1 exactly in IDLE.
REQ-013 IDLE, in_valid=1, in_vec!=0: latch in_vec into pending register, go BUSY next cycle.
REQ-014 IDLE, in_valid=1, in_vec==0: remain IDLE, zero_err=1 the following cycle only.
REQ-015 Accept at edge N SHALL give out_valid=1 from cycle after edge N (1-cycle latency).
REQ-016 BUSY: out_valid=1; out_idx SHALL be the selected set bit of pending (default: lowest index).
REQ-017 out_idx, out_valid, out_last SHALL depend only on registered state, never combinationally on in_* or out_ready.
REQ-018 out_last SHALL be 1 exactly when pending has one bit set.
REQ-019 out_valid=1, out_ready=1: clear selected bit; if out_last, go IDLE next cycle, else stay BUSY.
REQ-020 out_valid=1, out_ready=0: out_idx, out_last, pending SHALL hold stable.
REQ-021 Vector with k set bits SHALL emit exactly k indices, ascending priority order, one per accepted handshake.
REQ-022 Full throughput: one index per cycle while out_ready=1; in_ready SHALL rise the cycle after the last handshake.
REQ-023 in_valid during BUSY SHALL be ignored (no latch, no zero_err).
REQ-024 In IDLE out_valid=0, out_last=0, out_idx SHALL hold its last value.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, zero_err=0, RR pointer=0.
REQ-026 Reset during BUSY SHALL discard all pending indices; none emitted after release.
REQ-027 First acceptance possible on the first rising edge with rst_n=1.

Configuration
REQ-028 Macro ENC_ROUND_ROBIN_EN: when defined, selection SHALL be the first set pending bit at or above a 4-bit pointer, wrapping 15->0; pointer SHALL become out_idx+1 (mod 16) on each handshake and persist across vectors.
REQ-029 Without ENC_ROUND_ROBIN_EN: fixed lowest-index priority, no pointer register.

Structure
REQ-030 Package enc_pkg SHALL hold the FSM state typedef (IDLE, BUSY) and constants VEC_W=16, IDX_W=4.
REQ-031 Sub-module prio_enc16 (combinational 16-bit find-first-set with 4-bit result and any-bit flag) SHALL be used for selection; RR via masked-then-unmasked instances.

Verification
REQ-032 in_vec=16'h0001, out_ready=1 -> one beat idx=0, last=1; in_ready high again 2 cycles after accept.
REQ-033 in_vec=16'h8421, out_ready=1 -> idx 0,5,10,15 on consecutive cycles, last only with 15.
REQ-034 in_vec=16'h0000 -> zero_err pulse 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-035 in_vec=16'h0006, out_ready=0 for 3 cycles -> idx=1 held stable, then 1,2 once out_ready=1.
REQ-036 in_vec=16'hFFFF, rst_n=0 after 3 beats -> outputs zero immediately; no further beats after release.
REQ-037 ENC_ROUND_ROBIN_EN: 16'h0011 then 16'h0011 -> order 0,4 then 0,4 (pointer 5 wraps); after 16'h0010 then 16'h0011 -> 4 then 0,4.
